// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD engine: FSM state encoding,
// default operand width and the iteration-counter width rule.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_Y  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The worst case gcd(2^w-1, 1) takes 2^w-1 COMPUTE cycles, so w+1 bits
  // keep the counter from ever wrapping.
  function automatic int cnt_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// X/Y operand registers with a magnitude comparator, one shared
// subtractor (larger minus smaller) and zero detection.
module gcd_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_x,
  input  logic             load_y,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] x_val,
  output logic [WIDTH-1:0] y_val,
  output logic             x_eq_y,
  output logic             x_gt_y,
  output logic             x_zero,
  output logic             y_zero
);

  logic [WIDTH-1:0] x_reg;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] minuend;
  logic [WIDTH-1:0] subtrahend;
  logic [WIDTH-1:0] diff;

  // Comparator and zero detect drive both the FSM and the subtractor steering.
  always_comb begin
    x_eq_y = (x_reg == y_reg);
    x_gt_y = (x_reg > y_reg);
    x_zero = (x_reg == '0);
    y_zero = (y_reg == '0);
  end

  // Single subtractor: operands are swapped so the result never underflows.
  always_comb begin
    minuend    = x_gt_y ? x_reg : y_reg;
    subtrahend = x_gt_y ? y_reg : x_reg;
    diff       = minuend - subtrahend;
  end

  // Operand registers: loaded from the bus, or the larger one replaced by the difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      if (load_x) begin
        x_reg <= din;
      end else if (step && x_gt_y) begin
        x_reg <= diff;
      end
      if (load_y) begin
        y_reg <= din;
      end else if (step && !x_gt_y) begin
        y_reg <= diff;
      end
    end
  end

  assign x_val = x_reg;
  assign y_val = y_reg;

endmodule

// File: rtl/gcd_engine.sv
// Serial-entry subtractive GCD engine: Enter edge detector, control FSM,
// COMPUTE-cycle counter and held result register around gcd_datapath.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Enter,
  input  logic [WIDTH-1:0] Input,
  output logic [WIDTH-1:0] Output,
  output logic             Halt,
  output logic             Busy,
  output logic [CNT_W-1:0] Cycles
);

  state_t           state_reg;
  state_t           state_next;
  logic             enter_q;
  logic             enter_edge;
  logic             load_x;
  logic             load_y;
  logic             step;
  logic             finish;
  logic             terminate;
  logic [WIDTH-1:0] x_val;
  logic [WIDTH-1:0] y_val;
  logic             x_eq_y;
  logic             x_gt_y;
  logic             x_zero;
  logic             y_zero;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] result_reg;
  logic [CNT_W-1:0] cycles_reg;

  // Remember last Enter level so a held strobe yields a single edge.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      enter_q <= 1'b0;
    end else begin
      enter_q <= Enter;
    end
  end

  assign enter_edge = Enter & ~enter_q;

  gcd_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .load_x (load_x),
    .load_y (load_y),
    .step   (step),
    .din    (Input),
    .x_val  (x_val),
    .y_val  (y_val),
    .x_eq_y (x_eq_y),
    .x_gt_y (x_gt_y),
    .x_zero (x_zero),
    .y_zero (y_zero)
  );

  // Any zero operand or equal operands ends the computation.
  assign terminate = x_zero | y_zero | x_eq_y;

  // Result selection in priority order: X=0 gives Y, otherwise X.
  always_comb begin
    result_next = x_zero ? y_val : x_val;
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; Enter edges are ignored while computing.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (enter_edge) state_next = LOAD_Y;
      LOAD_Y:  if (enter_edge) state_next = COMPUTE;
      COMPUTE: if (terminate)  state_next = DONE;
      DONE:    if (enter_edge) state_next = LOAD_Y;
      default: state_next = IDLE;
    endcase
  end

  // Control outputs decoded from the current state.
  always_comb begin
    load_x = 1'b0;
    load_y = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    Halt   = 1'b0;
    Busy   = 1'b0;
    unique case (state_reg)
      IDLE:    load_x = enter_edge;
      LOAD_Y:  load_y = enter_edge;
      COMPUTE: begin
        Busy   = 1'b1;
        step   = ~terminate;
        finish = terminate;
      end
      DONE: begin
        Halt   = 1'b1;
        load_x = enter_edge;
      end
      default: ;
    endcase
  end

  // Result is captured on the final check cycle and held until the next one.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      result_reg <= '0;
    end else if (finish) begin
      result_reg <= result_next;
    end
  end

  // Counter cleared when Y is captured, counts every COMPUTE cycle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cycles_reg <= '0;
    end else if (load_y) begin
      cycles_reg <= '0;
    end else if (state_reg == COMPUTE) begin
      cycles_reg <= cycles_reg + CNT_W'(1);
    end
  end

  assign Output = result_reg;
  assign Cycles = cycles_reg;

endmodule
